// File: rtl/commit_ctrl.sv
// commit_ctrl -- dual-slot commit controller.
//   Consumes the two retiring writeback slots (slot 0 older) each cycle and
//   resolves exceptions, ERTN and IDLE in program order. All outputs are
//   registered, one cycle after the retiring inputs.
// Ports:
//   clk, rst_n (synchronous, active low)
//   commit_valid_i/exc_valid_i/ertn_i/idle_i/ll_set_i/ll_clr_i : per-slot flags
//   exc_ecode*/commit_pc*/commit_addr* : exception info per slot
//   reg_* / csr_* : GPR and CSR write requests per slot
//   eentry_i, era_i, int_pending_i : CSR-side inputs
//   rf_* / csr_* outputs : architectural write strobes and data
//   exc_* / ertn_commit_o : exception record and ERTN restore
//   flush_o / flush_target_o : pipeline kill + redirect
//   llbit_o, idle_stall_o
// Optional: define COMMIT_DIFFTEST_EN to add per-slot difftest trace ports
//   (plus commit_inst0_i/commit_inst1_i instruction words to trace).
module commit_ctrl #(
  parameter int unsigned          PC_W     = 32,
  parameter logic [PC_W-1:0]      RESET_PC = 'h1c000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           commit_valid_i,
  input  logic [1:0]           exc_valid_i,
  input  logic [5:0]           exc_ecode0_i,
  input  logic [5:0]           exc_ecode1_i,
  input  logic [PC_W-1:0]      commit_pc0_i,
  input  logic [PC_W-1:0]      commit_pc1_i,
  input  logic [PC_W-1:0]      commit_addr0_i,
  input  logic [PC_W-1:0]      commit_addr1_i,
  input  logic [1:0]           ertn_i,
  input  logic [1:0]           idle_i,
  input  logic [1:0]           ll_set_i,
  input  logic [1:0]           ll_clr_i,
  input  logic [1:0]           reg_we_i,
  input  logic [4:0]           reg_waddr0_i,
  input  logic [4:0]           reg_waddr1_i,
  input  logic [31:0]          reg_wdata0_i,
  input  logic [31:0]          reg_wdata1_i,
  input  logic [1:0]           csr_we_i,
  input  logic [13:0]          csr_addr0_i,
  input  logic [13:0]          csr_addr1_i,
  input  logic [31:0]          csr_wdata0_i,
  input  logic [31:0]          csr_wdata1_i,
  input  logic [PC_W-1:0]      eentry_i,
  input  logic [PC_W-1:0]      era_i,
  input  logic                 int_pending_i,
`ifdef COMMIT_DIFFTEST_EN
  input  logic [31:0]          commit_inst0_i,
  input  logic [31:0]          commit_inst1_i,
  output logic [PC_W-1:0]      debug_wb_pc0_o,
  output logic [PC_W-1:0]      debug_wb_pc1_o,
  output logic [31:0]          debug_wb_inst0_o,
  output logic [31:0]          debug_wb_inst1_o,
  output logic [1:0]           debug_wb_rf_we_o,
  output logic [4:0]           debug_wb_rf_wnum0_o,
  output logic [4:0]           debug_wb_rf_wnum1_o,
  output logic [31:0]          debug_wb_rf_wdata0_o,
  output logic [31:0]          debug_wb_rf_wdata1_o,
  output logic [1:0]           inst_valid_o,
  output logic                 excp_flush_o,
  output logic                 ertn_flush_o,
  output logic [5:0]           ecode_o,
`endif
  output logic [1:0]           rf_we_o,
  output logic [4:0]           rf_waddr0_o,
  output logic [4:0]           rf_waddr1_o,
  output logic [31:0]          rf_wdata0_o,
  output logic [31:0]          rf_wdata1_o,
  output logic [1:0]           csr_we_o,
  output logic [13:0]          csr_addr0_o,
  output logic [13:0]          csr_addr1_o,
  output logic [31:0]          csr_wdata0_o,
  output logic [31:0]          csr_wdata1_o,
  output logic                 exc_commit_o,
  output logic [PC_W-1:0]      exc_pc_o,
  output logic [PC_W-1:0]      exc_badv_o,
  output logic [5:0]           exc_ecode_o,
  output logic                 ertn_commit_o,
  output logic                 flush_o,
  output logic [PC_W-1:0]      flush_target_o,
  output logic                 llbit_o,
  output logic                 idle_stall_o
);

  typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_IDLE} state_e;

  state_e state_q, state_d;

  logic [1:0]      rf_we_q, rf_we_d, csr_we_q, csr_we_d;
  logic [4:0]      rf_waddr0_q, rf_waddr1_q;
  logic [31:0]     rf_wdata0_q, rf_wdata1_q, csr_wdata0_q, csr_wdata1_q;
  logic [13:0]     csr_addr0_q, csr_addr1_q;
  logic            exc_commit_q, exc_commit_d, ertn_commit_q, ertn_commit_d;
  logic            flush_q, flush_d, llbit_q, llbit_d;
  logic [PC_W-1:0] exc_pc_q, exc_pc_d, exc_badv_q, exc_badv_d;
  logic [PC_W-1:0] target_q, target_d;
  logic [5:0]      exc_ecode_q, exc_ecode_d;

  // Slot resolution shared by next-state and output logic.
  logic [1:0]      v, stop, cmt;
  logic            sel, any_stop, sel_exc, sel_ertn, sel_idle;
  logic [PC_W-1:0] sel_pc;

  always_comb begin
    v        = (state_q == ST_RUN) ? commit_valid_i : '0;
    stop     = v & (exc_valid_i | ertn_i | idle_i);
    // A slot's effects commit unless it excepts or an older slot stopped.
    cmt[0]   = v[0] & ~exc_valid_i[0];
    cmt[1]   = v[1] & ~stop[0] & ~exc_valid_i[1];
    sel      = ~stop[0];
    any_stop = |stop;
    sel_exc  = exc_valid_i[sel];
    sel_ertn = ertn_i[sel] & ~exc_valid_i[sel];
    sel_idle = idle_i[sel] & ~exc_valid_i[sel] & ~ertn_i[sel];
    sel_pc   = sel ? commit_pc1_i : commit_pc0_i;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:   if (any_stop) state_d = sel_idle ? ST_IDLE : ST_FLUSH;
      ST_FLUSH: state_d = ST_RUN;
      ST_IDLE:  if (int_pending_i) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_comb begin
    rf_we_d[0] = cmt[0] & reg_we_i[0] & (reg_waddr0_i != 5'd0);
    rf_we_d[1] = cmt[1] & reg_we_i[1] & (reg_waddr1_i != 5'd0);
    if (rf_we_d[1] && reg_waddr0_i == reg_waddr1_i) rf_we_d[0] = 1'b0;
    csr_we_d   = cmt & csr_we_i;
    if (csr_we_d[1] && csr_addr0_i == csr_addr1_i) csr_we_d[0] = 1'b0;

    llbit_d = llbit_q;
    for (int unsigned k = 0; k < 2; k++) begin
      if (cmt[k]) begin
        if (ll_set_i[k]) llbit_d = 1'b1;
        if (ll_clr_i[k] || ertn_i[k]) llbit_d = 1'b0;
      end
    end

    flush_d       = any_stop;
    exc_commit_d  = any_stop & sel_exc;
    ertn_commit_d = any_stop & sel_ertn;

    exc_pc_d    = exc_pc_q;
    exc_badv_d  = exc_badv_q;
    exc_ecode_d = exc_ecode_q;
    if (exc_commit_d) begin
      exc_pc_d    = sel_pc;
      exc_badv_d  = sel ? commit_addr1_i : commit_addr0_i;
      exc_ecode_d = sel ? exc_ecode1_i : exc_ecode0_i;
    end

    target_d = target_q;
    if (any_stop) begin
      if (sel_exc)       target_d = eentry_i;
      else if (sel_ertn) target_d = era_i;
      else               target_d = sel_pc + PC_W'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      rf_we_q       <= '0;
      rf_waddr0_q   <= '0;
      rf_waddr1_q   <= '0;
      rf_wdata0_q   <= '0;
      rf_wdata1_q   <= '0;
      csr_we_q      <= '0;
      csr_addr0_q   <= '0;
      csr_addr1_q   <= '0;
      csr_wdata0_q  <= '0;
      csr_wdata1_q  <= '0;
      exc_commit_q  <= 1'b0;
      exc_pc_q      <= '0;
      exc_badv_q    <= '0;
      exc_ecode_q   <= '0;
      ertn_commit_q <= 1'b0;
      flush_q       <= 1'b0;
      target_q      <= RESET_PC;
      llbit_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      rf_we_q       <= rf_we_d;
      rf_waddr0_q   <= reg_waddr0_i;
      rf_waddr1_q   <= reg_waddr1_i;
      rf_wdata0_q   <= reg_wdata0_i;
      rf_wdata1_q   <= reg_wdata1_i;
      csr_we_q      <= csr_we_d;
      csr_addr0_q   <= csr_addr0_i;
      csr_addr1_q   <= csr_addr1_i;
      csr_wdata0_q  <= csr_wdata0_i;
      csr_wdata1_q  <= csr_wdata1_i;
      exc_commit_q  <= exc_commit_d;
      exc_pc_q      <= exc_pc_d;
      exc_badv_q    <= exc_badv_d;
      exc_ecode_q   <= exc_ecode_d;
      ertn_commit_q <= ertn_commit_d;
      flush_q       <= flush_d;
      target_q      <= target_d;
      llbit_q       <= llbit_d;
    end
  end

  assign rf_we_o        = rf_we_q;
  assign rf_waddr0_o    = rf_waddr0_q;
  assign rf_waddr1_o    = rf_waddr1_q;
  assign rf_wdata0_o    = rf_wdata0_q;
  assign rf_wdata1_o    = rf_wdata1_q;
  assign csr_we_o       = csr_we_q;
  assign csr_addr0_o    = csr_addr0_q;
  assign csr_addr1_o    = csr_addr1_q;
  assign csr_wdata0_o   = csr_wdata0_q;
  assign csr_wdata1_o   = csr_wdata1_q;
  assign exc_commit_o   = exc_commit_q;
  assign exc_pc_o       = exc_pc_q;
  assign exc_badv_o     = exc_badv_q;
  assign exc_ecode_o    = exc_ecode_q;
  assign ertn_commit_o  = ertn_commit_q;
  assign flush_o        = flush_q;
  assign flush_target_o = target_q;
  assign llbit_o        = llbit_q;
  assign idle_stall_o   = (state_q == ST_IDLE);

`ifdef COMMIT_DIFFTEST_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      debug_wb_pc0_o       <= '0;
      debug_wb_pc1_o       <= '0;
      debug_wb_inst0_o     <= '0;
      debug_wb_inst1_o     <= '0;
      debug_wb_rf_we_o     <= '0;
      debug_wb_rf_wnum0_o  <= '0;
      debug_wb_rf_wnum1_o  <= '0;
      debug_wb_rf_wdata0_o <= '0;
      debug_wb_rf_wdata1_o <= '0;
      inst_valid_o         <= '0;
      excp_flush_o         <= 1'b0;
      ertn_flush_o         <= 1'b0;
      ecode_o              <= '0;
    end else begin
      debug_wb_pc0_o       <= commit_pc0_i;
      debug_wb_pc1_o       <= commit_pc1_i;
      debug_wb_inst0_o     <= commit_inst0_i;
      debug_wb_inst1_o     <= commit_inst1_i;
      debug_wb_rf_we_o     <= rf_we_d;
      debug_wb_rf_wnum0_o  <= reg_waddr0_i;
      debug_wb_rf_wnum1_o  <= reg_waddr1_i;
      debug_wb_rf_wdata0_o <= reg_wdata0_i;
      debug_wb_rf_wdata1_o <= reg_wdata1_i;
      inst_valid_o         <= cmt;
      excp_flush_o         <= exc_commit_d;
      ertn_flush_o         <= ertn_commit_d;
      ecode_o              <= exc_commit_d ? exc_ecode_d : '0;
    end
  end
`endif

endmodule
